// File: rtl/uart_rx_pkg.sv
// Purpose: shared types and constants for the UART serial receive front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_e;

  // Tick count at which the start bit centre is reached, counted from the
  // start-detect tick; data bits are then sampled one full bit later.
  function automatic int unsigned bit_centre(input int unsigned ovs_rate);
    return ovs_rate / 2 - 1;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Purpose: two-flop synchronizer for asynchronous inputs, reset to ResetValue.
// Latency: 2 clk_i cycles from d_i to q_o.
// Backpressure: none; free-running sampler.
// Ports: clk_i/rst_ni clock and async active-low reset, d_i async input,
//        q_o synchronized output.
module prim_flop_2sync #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// Purpose: UART receive deserializer; oversampled start detect, centre sampling.
// Latency: rx_valid_o one clock after the stop-sample tick (pin adds 2 clocks + tick wait).
// Backpressure: none; each frame is a one-cycle pulse, downstream must accept it.
// Ports: rx_i raw pin; tick_i OvsRate x baud strobe; rx_enable_i, parity_en_i,
//        parity_odd_i config; rx_valid_o/rx_data_o/frame_err_o/parity_err_o/break_o
//        frame result; rx_idle_o high while waiting for a start bit.
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int NDataBits = 8,
  parameter int OvsRate   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic                 rx_enable_i,
  input  logic                 tick_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  output logic                 rx_valid_o,
  output logic [NDataBits-1:0] rx_data_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 break_o,
  output logic                 rx_idle_o
);

  localparam int CntW = $clog2(OvsRate);
  localparam int IdxW = (NDataBits > 1) ? $clog2(NDataBits) : 1;
  localparam logic [CntW-1:0] CntCentre = CntW'(bit_centre(OvsRate));
  localparam logic [CntW-1:0] CntLast   = CntW'(OvsRate - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NDataBits - 1);

  logic                 rx_s;
  uart_rx_state_e       state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [NDataBits-1:0] shift_q;
  logic                 par_acc_q;
  logic                 par_err_q;
  logic                 all_zero_q;
  logic                 par_en_q;
  logic                 par_odd_q;

  // Per-tick strobes decoded from the FSM.
  logic cnt_clr;
  logic start_exit;
  logic data_smp;
  logic par_smp;
  logic stop_smp;

  prim_flop_2sync #(
    .Width      (1),
    .ResetValue (1'b1)
  ) u_rx_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    start_exit = 1'b0;
    data_smp   = 1'b0;
    par_smp    = 1'b0;
    stop_smp   = 1'b0;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_s && rx_enable_i) begin
            state_d = START;
            cnt_clr = 1'b1;
          end
        end
        START: begin
          if (cnt_q == CntCentre) begin
            if (rx_s) begin
              state_d = IDLE;  // line back high at the centre: glitch
            end else begin
              state_d    = DATA;
              cnt_clr    = 1'b1;
              start_exit = 1'b1;
            end
          end
        end
        DATA: begin
          if (cnt_q == CntLast) begin
            data_smp = 1'b1;
            if (idx_q == IdxLast) state_d = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt_q == CntLast) begin
            par_smp = 1'b1;
            state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_q == CntLast) begin
            stop_smp = 1'b1;
            // A low stop bit may be a break; wait for the line to recover
            // before hunting for the next start bit.
            state_d  = rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Disable aborts the frame; a stop sample on the same cycle still reports.
    if (!rx_enable_i) state_d = IDLE;
  end

  // The counter free-runs outside a frame; it is cleared on every entry
  // to a state that depends on it, so the idle value never matters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (tick_i) begin
      cnt_q <= cnt_clr ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      all_zero_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
    end else begin
      if (start_exit) begin
        idx_q      <= '0;
        par_acc_q  <= 1'b0;
        par_err_q  <= 1'b0;
        all_zero_q <= 1'b1;
        par_en_q   <= parity_en_i;
        par_odd_q  <= parity_odd_i;
      end
      if (data_smp) begin
        idx_q   <= idx_q + IdxW'(1);
        shift_q <= {rx_s, shift_q[NDataBits-1:1]};
      end
      if (data_smp || par_smp) begin
        par_acc_q  <= par_acc_q ^ rx_s;
        all_zero_q <= all_zero_q & ~rx_s;
      end
      // Odd parity wants the XOR over data+parity to be 1, even wants 0.
      if (par_smp) par_err_q <= par_acc_q ^ rx_s ^ par_odd_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_o   <= 1'b0;
      rx_data_o    <= '0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      break_o      <= 1'b0;
    end else begin
      rx_valid_o <= stop_smp;
      if (stop_smp) begin
        rx_data_o    <= shift_q;
        frame_err_o  <= ~rx_s;
        parity_err_o <= par_en_q & par_err_q;
        break_o      <= all_zero_q & ~rx_s;
      end
    end
  end

  assign rx_idle_o = (state_q == IDLE);

endmodule
